spi_flash_rd_seq: RTL and testbench
===================================

Name: spi_flash_rd_seq

Overview:
- Read sequencer that sits directly upstream of the SPI flash master (command/address/data + validflag/tready interface).
- Accepts a host burst-read request (start address, byte count) and issues one single-byte READ transaction per byte to the master.
- Collects the returned bytes and packs them into 32-bit words delivered on a valid/ready stream.
- Includes a per-byte timeout so a stalled SPI link cannot hang the host.

Parameters:
- CMD_READ, 8'h03, command byte driven on m_command for every transaction.
- TIMEOUT, 1024, clk cycles to wait for m_tready after a validflag pulse before aborting; must be ≥ 2.
- TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0); release is synchronous to clk.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  24  start flash byte address.
- req_len  in  8  byte count; 1..255 literal, 0 means 256.
- rdata  out  32  packed word; byte k of the word sits at bits [8k+7:8k].
- rdata_valid  out  1  word valid.
- rdata_ready  in  1  host accepts word.
- rdata_last  out  1  qualifies the final word of the burst.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky; set on abort, cleared on the next accepted request.
- m_command  out  8  to master.
- m_address  out  24  to master.
- m_data_in  out  8  to master; always 8'h00 (read only).
- m_validflag  out  1  one-clk pulse that starts a transaction.
- m_tready  in  1  one-clk pulse from master when m_data_out is valid.
- m_data_out  in  8  byte returned by master.

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. Internal state: IDLE, counters 0.
  - Reset mid-burst aborts immediately: no further m_validflag, rdata_valid drops, the partial word is discarded.
- States: IDLE, ISSUE, WAIT, PUSH.
- IDLE:
  - req_valid & req_ready accepts the request and latches addr and len (0 maps to 256).
  - Clears the byte index, the word lane (0..3), the word register and err_timeout.
  - Next state: ISSUE.
- ISSUE:
  - Drives m_validflag = 1 for exactly one cycle.
  - m_command = CMD_READ; m_address = current address. m_command and m_address stay stable until leaving WAIT.
  - Clears the timeout counter. Next state: WAIT.
- WAIT:
  - On m_tready = 1, write m_data_out into lane bits [8*lane+7:8*lane] and decrement the remaining count.
    - If lane = 3 or remaining becomes 0, go to PUSH.
    - Otherwise lane += 1, address += 1, go to ISSUE.
  - m_tready is ignored in every other state, including the ISSUE cycle itself.
  - The timeout counter increments each WAIT cycle. Reaching TIMEOUT without m_tready:
    - set err_timeout, drop the partial word, go to IDLE;
    - any m_tready arriving later is ignored.
- PUSH:
  - rdata_valid = 1; rdata holds the packed word. Unfilled upper lanes of a partial final word are 0.
  - rdata_last = 1 when remaining = 0.
  - Hold rdata, rdata_valid and rdata_last stable until rdata_ready.
  - On rdata_valid & rdata_ready:
    - if remaining = 0, go to IDLE;
    - otherwise clear the word, lane = 0, address += 1, go to ISSUE.
  - rdata_ready while rdata_valid = 0 has no effect.
- Address arithmetic is 24-bit modulo: 24'hFFFFFF + 1 wraps to 24'h000000 within a burst.
- Throughput: at most one transaction in flight; a new m_validflag never issues before the previous m_tready (or timeout).
- Latency: request accept → first m_validflag = 1 clk. Fourth m_tready → rdata_valid = 1 clk.
- A request arriving while busy is not accepted (req_ready = 0); req_valid is held by the host.

Test Plan:
- Reset: rst = 0 mid-burst, after 3 bytes → all outputs 0 except req_ready = 1, no m_validflag afterward; then rst = 1 and a fresh request works.
- Aligned burst: req_addr = 24'h000100, len = 8; model returns 8'h11..8'h88 (3-cycle tready delay) → rdata = 32'h44332211 then 32'h88776655 with last; m_address sequence 0x100..0x107.
- Partial word plus backpressure: len = 5, bytes A0..A4, rdata_ready held low 10 cycles → second word 32'h000000A4 with last, stable during the stall, no m_validflag while in PUSH.
- Wrap and len = 0: req_addr = 24'hFFFFFE, len = 0 → 256 transactions, addresses FFFFFE, FFFFFF, 000000 …, 64 words, last only on the 64th.
- Timeout: model never asserts m_tready on byte 2 → exactly TIMEOUT cycles in WAIT, then err_timeout = 1, busy = 0, no rdata_valid for the partial word; a late tready is ignored; the next request clears err_timeout.
- Spurious tready: m_tready pulsed in IDLE and in PUSH → no state change, no byte captured.

Source files
------------

// File: rtl/spi_flash_rd_seq_if.sv
// Host request/word stream plus SPI flash master link
// for the burst read sequencer.
interface spi_flash_rd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;

  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic        rdata_last;

  logic        busy;
  logic        err_timeout;

  logic [7:0]  m_command;
  logic [23:0] m_address;
  logic [7:0]  m_data_in;
  logic        m_validflag;
  logic        m_tready;
  logic [7:0]  m_data_out;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    input  rdata_ready,
    input  m_tready,
    input  m_data_out,
    output req_ready,
    output rdata,
    output rdata_valid,
    output rdata_last,
    output busy,
    output err_timeout,
    output m_command,
    output m_address,
    output m_data_in,
    output m_validflag
  );

  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    output rdata_ready,
    output m_tready,
    output m_data_out,
    input  req_ready,
    input  rdata,
    input  rdata_valid,
    input  rdata_last,
    input  busy,
    input  err_timeout,
    input  m_command,
    input  m_address,
    input  m_data_in,
    input  m_validflag
  );
endinterface

// File: rtl/spi_flash_rd_seq.sv
// Burst read sequencer: one single-byte READ per byte,
// packed little-endian into 32-bit words with timeout abort.
module spi_flash_rd_seq #(
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned TO_W     = 11
) (
  input logic clk,
  input logic rst,
  spi_flash_rd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    PUSH
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  state_e          state_q;
  logic [23:0]     addr_q;
  logic [23:0]     addr_d;
  logic [8:0]      rem_q;
  logic [8:0]      rem_d;
  logic [1:0]      lane_q;
  logic [31:0]     word_q;
  logic [31:0]     word_d;
  logic [TO_W-1:0] to_q;
  logic [7:0]      cmd_q;
  logic            vf_q;
  logic            rv_q;
  logic            rl_q;
  logic            rr_q;
  logic            busy_q;
  logic            err_q;
  logic            fill_done;

  always_comb begin
    addr_d = addr_q + 24'd1;
    rem_d  = rem_q - 9'd1;
    word_d = word_q;
    unique case (lane_q)
      2'd0: word_d[7:0]   = bus.m_data_out;
      2'd1: word_d[15:8]  = bus.m_data_out;
      2'd2: word_d[23:16] = bus.m_data_out;
      2'd3: word_d[31:24] = bus.m_data_out;
      default: word_d = word_q;
    endcase
  end

  // Word closes on a full lane set or on the burst's final byte
  assign fill_done = (lane_q == 2'd3) ||
                     (rem_q == 9'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      to_q    <= '0;
      cmd_q   <= '0;
      vf_q    <= 1'b0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
      rr_q    <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && rr_q) begin
            addr_q  <= bus.req_addr;
            rem_q   <= (bus.req_len == 8'd0) ?
                       9'd256 : {1'b0, bus.req_len};
            lane_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            cmd_q   <= CMD_READ;
            vf_q    <= 1'b1;
            rr_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          vf_q    <= 1'b0;
          to_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.m_tready) begin
            word_q <= word_d;
            rem_q  <= rem_d;
            if (fill_done) begin
              rv_q    <= 1'b1;
              rl_q    <= (rem_q == 9'd1);
              state_q <= PUSH;
            end else begin
              lane_q  <= lane_q + 2'd1;
              addr_q  <= addr_d;
              vf_q    <= 1'b1;
              state_q <= ISSUE;
            end
          end else if (to_q == TO_LAST) begin
            // Abort: partial word is never delivered
            err_q   <= 1'b1;
            word_q  <= '0;
            rr_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        PUSH: begin
          if (bus.rdata_ready) begin
            rv_q <= 1'b0;
            rl_q <= 1'b0;
            if (rem_q == 9'd0) begin
              rr_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              word_q  <= '0;
              lane_q  <= '0;
              addr_q  <= addr_d;
              vf_q    <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = rr_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;
  assign bus.rdata       = word_q;
  assign bus.rdata_valid = rv_q;
  assign bus.rdata_last  = rl_q;
  assign bus.m_command   = cmd_q;
  assign bus.m_address   = addr_q;
  assign bus.m_data_in   = 8'h00;
  assign bus.m_validflag = vf_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Scoreboard bench for spi_flash_rd_seq with a
// delayed-response SPI master model.
module tb_spi_flash_rd_seq;

  localparam int TIMEOUT = 1024;
  localparam int DLY     = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_flash_rd_seq_if bus();

  spi_flash_rd_seq #(
    .CMD_READ(8'h03),
    .TIMEOUT (TIMEOUT),
    .TO_W    (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_addr[$];
  logic [7:0]  flash_q[$];
  logic [32:0] exp_w[$];

  int          pend = 0;
  logic [7:0]  pend_byte;
  int          txn = 0;
  int          burst_n = 0;
  int          hang_idx = -1;
  int unsigned hang_cyc = 0;
  bit          spur = 1'b0;
  bit          chk_push = 1'b0;
  int          tready_cnt = 0;

  // Flash master model: answers each validflag DLY cycles later
  initial begin
    bus.m_tready   = 1'b0;
    bus.m_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (chk_push) begin
        chk("push_lat", bus.rdata_valid, 1);
        chk_push = 1'b0;
      end
      bus.m_tready = 1'b0;
      if (spur) begin
        bus.m_tready   = 1'b1;
        bus.m_data_out = 8'hEE;
        spur = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.m_tready   = 1'b1;
          bus.m_data_out = pend_byte;
          tready_cnt++;
          if (((txn - 1) % 4 == 3) || (txn == burst_n))
            chk_push = 1'b1;
        end
      end
      if (bus.m_validflag) begin
        chk("vf_overlap", 32'(pend), 0);
        chk("vf_expected", 32'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0)
          chk("m_address", 32'(bus.m_address),
              32'(exp_addr.pop_front()));
        chk("m_command", 32'(bus.m_command), 32'h03);
        chk("m_data_in", 32'(bus.m_data_in), 0);
        if (txn == hang_idx) begin
          hang_cyc = cyc;
        end else if (flash_q.size() != 0) begin
          pend      = DLY;
          pend_byte = flash_q.pop_front();
        end
        txn++;
      end
    end
  end

  logic [31:0] hold_w;
  logic        hold_l;
  bit          hold_v = 1'b0;

  // Output monitor: scoreboard pop on handshake, stability on stall
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (bus.rdata_valid) begin
        chk("vf_in_push", bus.m_validflag, 0);
        if (hold_v) begin
          chk("hold_word", bus.rdata, hold_w);
          chk("hold_last", bus.rdata_last, hold_l);
        end
        if (bus.rdata_ready) begin
          hold_v = 1'b0;
          chk("word_avail", 32'(exp_w.size() != 0), 1);
          if (exp_w.size() != 0) begin
            e = exp_w.pop_front();
            chk("rdata", bus.rdata, e[31:0]);
            chk("rdata_last", bus.rdata_last, e[32]);
          end
        end else begin
          hold_v = 1'b1;
          hold_w = bus.rdata;
          hold_l = bus.rdata_last;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic start_burst(input logic [23:0] a,
                             input logic [7:0]  l,
                             input int          pat);
    int n;
    logic [31:0] w;
    logic [7:0]  b;
    int k;
    n = (l == 8'd0) ? 256 : int'(l);
    w = '0;
    burst_n = n;
    txn = 0;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       b = 8'(8'h11 * (i + 1));
        1:       b = 8'(8'hA0 + i);
        default: b = 8'(i) ^ 8'h5A;
      endcase
      flash_q.push_back(b);
      exp_addr.push_back(a + 24'(i));
      w[8*(i%4) +: 8] = b;
      if ((i % 4 == 3) || (i == n - 1)) begin
        exp_w.push_back({(i == n - 1), w});
        w = '0;
      end
    end
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    chk("vf_latency", bus.m_validflag, 1);
    chk("busy_set", bus.busy, 1);
    chk("req_ready_busy", bus.req_ready, 0);
    chk("err_cleared", bus.err_timeout, 0);
  endtask

  task automatic wait_idle(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk);
      #2;
      if (!bus.busy && exp_w.size() == 0) break;
    end
    chk("burst_done", bus.busy, 0);
    chk("words_left", 32'(exp_w.size()), 0);
  endtask

  task automatic wait_valid(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk);
      #2;
      if (bus.rdata_valid) break;
    end
    chk("word_arrives", bus.rdata_valid, 1);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.rdata_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rvalid", bus.rdata_valid, 0);
    chk("rst_rlast", bus.rdata_last, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_vf", bus.m_validflag, 0);
    chk("rst_cmd", 32'(bus.m_command), 0);
    chk("rst_addr", 32'(bus.m_address), 0);
    rst = 1'b1;

    // aligned 8-byte burst
    start_burst(24'h000100, 8'd8, 0);
    wait_idle(2000);

    // partial final word under backpressure, tready spurious in PUSH
    bus.rdata_ready = 1'b0;
    start_burst(24'h000400, 8'd5, 1);
    for (int w = 0; w < 2; w++) begin
      wait_valid(500);
      repeat (4) @(posedge clk);
      #2;
      spur = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      bus.rdata_ready = 1'b1;
      @(posedge clk);
      #2;
      bus.rdata_ready = 1'b0;
    end
    bus.rdata_ready = 1'b1;
    wait_idle(500);

    // spurious tready in IDLE
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("spur_idle_busy", bus.busy, 0);
    chk("spur_idle_rdy", bus.req_ready, 1);
    chk("spur_idle_rv", bus.rdata_valid, 0);

    // len 0 = 256 bytes across the 24-bit wrap
    start_burst(24'hFFFFFE, 8'd0, 2);
    wait_idle(5000);

    // timeout on the second byte
    hang_idx = 1;
    start_burst(24'h000300, 8'd4, 0);
    for (int k = 0; k < TIMEOUT + 200; k++) begin
      @(posedge clk);
      #2;
      if (!bus.busy) break;
    end
    chk("to_cycles", cyc - hang_cyc, TIMEOUT + 1);
    chk("to_err", bus.err_timeout, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_rvalid", bus.rdata_valid, 0);
    chk("to_word_held_back", 32'(exp_w.size()), 1);
    exp_w.delete();
    exp_addr.delete();
    flash_q.delete();
    hang_idx = -1;
    spur = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("late_tready_busy", bus.busy, 0);
    chk("late_tready_rv", bus.rdata_valid, 0);
    chk("err_sticky", bus.err_timeout, 1);

    // next request clears the error
    start_burst(24'h000500, 8'd1, 1);
    wait_idle(200);

    // reset mid-burst after three bytes
    tready_cnt = 0;
    start_burst(24'h000200, 8'd8, 0);
    for (int k = 0; k < 200; k++) begin
      if (tready_cnt >= 3) break;
      @(posedge clk);
      #2;
    end
    chk("three_bytes", 32'(tready_cnt), 3);
    rst = 1'b0;
    pend = 0;
    chk_push = 1'b0;
    bus.m_tready = 1'b0;
    flash_q.delete();
    exp_addr.delete();
    exp_w.delete();
    #1;
    chk("mid_rst_rdy", bus.req_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rv", bus.rdata_valid, 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    chk("mid_rst_addr", 32'(bus.m_address), 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      chk("mid_rst_vf", bus.m_validflag, 0);
    end
    rst = 1'b1;
    start_burst(24'h000600, 8'd4, 2);
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
